// File: rtl/spi_cfg_pkg.sv
// Shared address map and control-bit positions for the SPI configuration register bank.
package spi_cfg_pkg;

    localparam logic [7:0] A_MAC0   = 8'h00;
    localparam logic [7:0] A_IP0    = 8'h06;
    localparam logic [7:0] A_PORT0  = 8'h0A;
    localparam logic [7:0] A_CTRL   = 8'h0C;
    localparam logic [7:0] A_COMMIT = 8'h0D;
    localparam logic [7:0] A_CNT    = 8'h0E;
    localparam logic [7:0] A_ID     = 8'h0F;

    localparam int NUM_SHADOW    = 13;
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_LOCK_BIT = 7;

    function automatic logic isShadowAddr(input logic [7:0] addr);
        return addr < 8'(NUM_SHADOW);
    endfunction

endpackage

// File: rtl/cfg_byte_bank.sv
// Shadow/live byte pair: writes land in shadow, commit copies every shadow byte to live at once.
// Byte 0 sits in the most significant byte of the flattened vectors.
module cfg_byte_bank
    import spi_cfg_pkg::*;
#(
    parameter logic [NUM_SHADOW*8-1:0] RESET_VAL = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wrEn_i,
    input  logic [3:0]              wrIdx_i,
    input  logic [7:0]              wrData_i,
    input  logic                    commit_i,
    output logic [NUM_SHADOW*8-1:0] shadow_o,
    output logic [NUM_SHADOW*8-1:0] live_o
);

    logic [NUM_SHADOW*8-1:0] shadow_q;
    logic [NUM_SHADOW*8-1:0] shadow_d;
    logic [NUM_SHADOW*8-1:0] live_q;

    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_SHADOW; i++) begin
            if (wrIdx_i == 4'(i)) begin
                shadow_d[(NUM_SHADOW-1-i)*8 +: 8] = wrData_i;
            end
        end
    end

    // Live samples the old shadow value, so a write on the commit edge misses this commit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= RESET_VAL;
            live_q   <= RESET_VAL;
        end else begin
            if (commit_i) begin
                live_q <= shadow_q;
            end
            if (wrEn_i) begin
                shadow_q <= shadow_d;
            end
        end
    end

    assign shadow_o = shadow_q;
    assign live_o   = live_q;

endmodule

// File: rtl/spi_cfg_regs.sv
// Configuration register bank behind the SPI local-bus gate with atomic MAC/IP/port commit.
// Optional feature macro: CFG_LOCK_EN (commit with ctrl bit7 set locks out all further writes).
module spi_cfg_regs
    import spi_cfg_pkg::*;
#(
    parameter logic [47:0] DEFAULT_MAC  = 48'h12555500012d,
    parameter logic [31:0] DEFAULT_IP   = 32'hc0a80005,
    parameter logic [15:0] DEFAULT_PORT = 16'd3000,
    parameter logic [7:0]  ID_BYTE      = 8'hb5
) (
    input  logic        config_clk,
    input  logic        config_rst,
    input  logic        config_w,
    input  logic        config_r,
    input  logic [7:0]  config_a,
    input  logic [7:0]  config_d,
    output logic [7:0]  tx_data,
    output logic [47:0] mac,
    output logic [31:0] ip,
    output logic [15:0] udp_port,
    output logic        enable,
    output logic        cfg_valid,
    output logic        cfg_update
);

    localparam logic [NUM_SHADOW*8-1:0] BANK_RESET = {DEFAULT_MAC, DEFAULT_IP, DEFAULT_PORT, 8'h00};

    logic [NUM_SHADOW*8-1:0] shadowFlat;
    logic [NUM_SHADOW*8-1:0] liveFlat;
    logic [6:0]              ctrlLiveUnused;
    logic                    lock;
    logic                    wrOk;
    logic                    shadowWr;
    logic                    commitReq;
    logic [7:0]              rdByte;

    logic                    commitPend_q;
    logic                    cfgUpdate_q;
    logic                    cfgValid_q;
    logic [7:0]              commitCnt_q;
    logic [7:0]              txData_q;

    assign wrOk      = config_w & ~lock;
    assign shadowWr  = wrOk & isShadowAddr(config_a);
    assign commitReq = wrOk & (config_a == A_COMMIT);

    cfg_byte_bank #(
        .RESET_VAL (BANK_RESET)
    ) u_bank (
        .clk_i    (config_clk),
        .rst_i    (config_rst),
        .wrEn_i   (shadowWr),
        .wrIdx_i  (config_a[3:0]),
        .wrData_i (config_d),
        .commit_i (commitPend_q),
        .shadow_o (shadowFlat),
        .live_o   (liveFlat)
    );

`ifdef CFG_LOCK_EN
    logic lock_q;

    always_ff @(posedge config_clk or posedge config_rst) begin
        if (config_rst) begin
            lock_q <= 1'b0;
        end else if (commitPend_q && shadowFlat[CTRL_LOCK_BIT]) begin
            lock_q <= 1'b1;
        end
    end

    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

    // The commit request is registered so live changes exactly one edge after the COMMIT write.
    always_ff @(posedge config_clk or posedge config_rst) begin
        if (config_rst) begin
            commitPend_q <= 1'b0;
            cfgUpdate_q  <= 1'b0;
            cfgValid_q   <= 1'b0;
            commitCnt_q  <= 8'h00;
        end else begin
            commitPend_q <= commitReq;
            cfgUpdate_q  <= commitPend_q;
            if (commitPend_q) begin
                cfgValid_q  <= 1'b1;
                commitCnt_q <= commitCnt_q + 8'h01;
            end
        end
    end

    always_comb begin
        rdByte = 8'h00;
        for (int i = 0; i < NUM_SHADOW; i++) begin
            if (config_a == 8'(i)) begin
                rdByte = shadowFlat[(NUM_SHADOW-1-i)*8 +: 8];
            end
        end
        if (config_a == A_CNT) begin
            rdByte = commitCnt_q;
        end
        if (config_a == A_ID) begin
            rdByte = ID_BYTE;
        end
`ifdef CFG_LOCK_EN
        if (config_a == A_CTRL) begin
            rdByte[CTRL_LOCK_BIT] = lock;
        end
`endif
    end

    always_ff @(posedge config_clk or posedge config_rst) begin
        if (config_rst) begin
            txData_q <= 8'h00;
        end else if (config_r) begin
            txData_q <= rdByte;
        end
    end

    assign ctrlLiveUnused = liveFlat[7:1];

    assign tx_data    = txData_q;
    assign mac        = liveFlat[NUM_SHADOW*8-1 -: 48];
    assign ip         = liveFlat[NUM_SHADOW*8-49 -: 32];
    assign udp_port   = liveFlat[NUM_SHADOW*8-81 -: 16];
    assign enable     = liveFlat[CTRL_EN_BIT];
    assign cfg_valid  = cfgValid_q;
    assign cfg_update = cfgUpdate_q;

endmodule

// File: tb/tb_spi_cfg_regs.sv
// Self-checking bench for spi_cfg_regs; covers the lock path when CFG_LOCK_EN is defined.
module tb_spi_cfg_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        w;
    logic        r;
    logic [7:0]  a;
    logic [7:0]  d;
    logic [7:0]  tx_data;
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] udp_port;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_update;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       isWrite;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] expTx;
    } vec_t;

    vec_t vecs[16];

    spi_cfg_regs dut (
        .config_clk (clk),
        .config_rst (rst),
        .config_w   (w),
        .config_r   (r),
        .config_a   (a),
        .config_d   (d),
        .tx_data    (tx_data),
        .mac        (mac),
        .ip         (ip),
        .udp_port   (udp_port),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_update (cfg_update)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; the task returns on the next falling edge.
    task automatic applyStimulus(input logic wi, input logic ri, input logic [7:0] ai, input logic [7:0] di);
        w = wi;
        r = ri;
        a = ai;
        d = di;
        @(negedge clk);
        w = 1'b0;
        r = 1'b0;
    endtask

    task automatic readCheck(input string name, input logic [7:0] addr, input logic [7:0] exp);
        applyStimulus(1'b0, 1'b1, addr, 8'h00);
        checkOutput(name, 64'(tx_data), 64'(exp));
    endtask

    initial begin
        logic [47:0] expMac;

        rst = 1'b1;
        w = 1'b0;
        r = 1'b0;
        a = 8'h00;
        d = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rst_mac", 64'(mac), 64'h12555500012d);
        checkOutput("rst_ip", 64'(ip), 64'hc0a80005);
        checkOutput("rst_port", 64'(udp_port), 64'd3000);
        checkOutput("rst_valid", 64'(cfg_valid), 64'd0);
        checkOutput("rst_update", 64'(cfg_update), 64'd0);
        checkOutput("rst_enable", 64'(enable), 64'd0);
        checkOutput("rst_tx", 64'(tx_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        vecs[0]  = '{1'b0, 8'h0F, 8'h00, 8'hB5};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h12};
        vecs[2]  = '{1'b0, 8'h05, 8'h00, 8'h2D};
        vecs[3]  = '{1'b0, 8'h06, 8'h00, 8'hC0};
        vecs[4]  = '{1'b0, 8'h09, 8'h00, 8'h05};
        vecs[5]  = '{1'b0, 8'h0A, 8'h00, 8'h0B};
        vecs[6]  = '{1'b0, 8'h0B, 8'h00, 8'hB8};
        vecs[7]  = '{1'b0, 8'h0C, 8'h00, 8'h00};
        vecs[8]  = '{1'b0, 8'h0D, 8'h00, 8'h00};
        vecs[9]  = '{1'b0, 8'h10, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 8'hFF, 8'h00, 8'h00};
        vecs[11] = '{1'b1, 8'h0A, 8'h12, 8'h00};
        vecs[12] = '{1'b0, 8'h0A, 8'h00, 8'h12};
        vecs[13] = '{1'b1, 8'h0E, 8'h77, 8'h00};
        vecs[14] = '{1'b0, 8'h0E, 8'h00, 8'h00};
        vecs[15] = '{1'b1, 8'h0F, 8'h00, 8'h00};

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].isWrite) begin
                applyStimulus(1'b1, 1'b0, vecs[i].addr, vecs[i].data);
            end else begin
                readCheck($sformatf("vec%0d_rd%02h", i, vecs[i].addr), vecs[i].addr, vecs[i].expTx);
            end
        end
        readCheck("id_after_ro_write", 8'h0F, 8'hB5);
        checkOutput("port_before_commit", 64'(udp_port), 64'd3000);

        applyStimulus(1'b1, 1'b0, 8'h06, 8'hC0);
        applyStimulus(1'b1, 1'b0, 8'h07, 8'hA8);
        applyStimulus(1'b1, 1'b0, 8'h08, 8'h01);
        applyStimulus(1'b1, 1'b0, 8'h09, 8'h64);
        checkOutput("ip_no_commit", 64'(ip), 64'hc0a80005);
        readCheck("shadow_ip1", 8'h07, 8'hA8);

        applyStimulus(1'b1, 1'b0, 8'h0D, 8'h00);
        checkOutput("ip_before_commit_edge", 64'(ip), 64'hc0a80005);
        checkOutput("update_before_commit_edge", 64'(cfg_update), 64'd0);
        applyStimulus(1'b1, 1'b0, 8'h09, 8'h99);
        checkOutput("ip_committed", 64'(ip), 64'hc0a80164);
        checkOutput("port_committed", 64'(udp_port), 64'h12B8);
        checkOutput("update_pulse", 64'(cfg_update), 64'd1);
        checkOutput("valid_set", 64'(cfg_valid), 64'd1);
        readCheck("shadow_ip3_late_write", 8'h09, 8'h99);
        checkOutput("update_cleared", 64'(cfg_update), 64'd0);
        checkOutput("ip_kept_prewrite", 64'(ip), 64'hc0a80164);
        readCheck("cnt_one", 8'h0E, 8'h01);

        for (int i = 0; i < 255; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h0D, 8'h00);
        end
        @(negedge clk);
        readCheck("cnt_wrap", 8'h0E, 8'h00);
        checkOutput("valid_sticky", 64'(cfg_valid), 64'd1);
        checkOutput("ip_after_bulk", 64'(ip), 64'hc0a80199);
        applyStimulus(1'b1, 1'b0, 8'h20, 8'h55);
        readCheck("reserved_rd", 8'h20, 8'h00);
        checkOutput("mac_after_reserved", 64'(mac), 64'h12555500012d);
        checkOutput("ip_after_reserved", 64'(ip), 64'hc0a80199);

        applyStimulus(1'b1, 1'b1, 8'h00, 8'hAA);
        checkOutput("rd_pre_write", 64'(tx_data), 64'h12);
        readCheck("rd_post_write", 8'h00, 8'hAA);
        checkOutput("mac_shadow_only", 64'(mac), 64'h12555500012d);

        applyStimulus(1'b1, 1'b0, 8'h0C, 8'h81);
        applyStimulus(1'b1, 1'b0, 8'h0D, 8'h00);
        @(negedge clk);
        expMac = 48'hAA5555_00012d;
        checkOutput("enable_set", 64'(enable), 64'd1);
        checkOutput("mac_ctrl_commit", 64'(mac), 64'(expMac));
        readCheck("ctrl_rd", 8'h0C, 8'h81);
        readCheck("cnt_after_ctrl", 8'h0E, 8'h01);

        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h0D, 8'h00);
        @(negedge clk);
`ifdef CFG_LOCK_EN
        checkOutput("lock_mac_hold", 64'(mac), 64'(expMac));
        checkOutput("lock_no_update", 64'(cfg_update), 64'd0);
        readCheck("lock_cnt_hold", 8'h0E, 8'h01);
        readCheck("lock_shadow_hold", 8'h00, 8'hAA);
`else
        expMac = 48'h005555_00012d;
        checkOutput("nolock_mac", 64'(mac), 64'(expMac));
        checkOutput("nolock_update", 64'(cfg_update), 64'd1);
        readCheck("nolock_cnt", 8'h0E, 8'h02);
        readCheck("nolock_shadow", 8'h00, 8'h00);
`endif

        applyStimulus(1'b1, 1'b0, 8'h06, 8'h11);
        applyStimulus(1'b1, 1'b0, 8'h0D, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst2_mac", 64'(mac), 64'h12555500012d);
        checkOutput("rst2_ip", 64'(ip), 64'hc0a80005);
        checkOutput("rst2_valid", 64'(cfg_valid), 64'd0);
        checkOutput("rst2_update", 64'(cfg_update), 64'd0);
        checkOutput("rst2_enable", 64'(enable), 64'd0);
        readCheck("rst2_ctrl", 8'h0C, 8'h00);
        readCheck("rst2_cnt", 8'h0E, 8'h00);
        readCheck("rst2_shadow_ip0", 8'h06, 8'hC0);

        applyStimulus(1'b1, 1'b0, 8'h06, 8'h11);
        applyStimulus(1'b1, 1'b0, 8'h0D, 8'h00);
        @(negedge clk);
        checkOutput("unlocked_commit_ip", 64'(ip), 64'h11a80005);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
